// File: rtl/pipemem_arbiter_pkg.sv
// Shared constants for the IF/MEM unified-memory arbiter.
package pipemem_arbiter_pkg;

    // Arbiter FSM state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_IBUSY = 2'd1;
    localparam logic [1:0] ST_DBUSY = 2'd2;

    // Value loaded into the read-data register of a requester whose access timed out.
    localparam logic [31:0] TIMEOUT_FILL = 32'h0;

endpackage

// File: rtl/pipemem_timer.sv
// Loadable down-counter that flags the cycle in which a memory access has
// waited its full budget without an acknowledge.
module pipemem_timer
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    // Expire on the last permitted waiting cycle, so the abort edge is the
    // one ending the load_val-th busy cycle.
    assign expire = dec && (cnt == CNT_W'(1));

    // Reload on issue, count down once per busy cycle without acknowledge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipemem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the
// MEM stage. One transaction at a time, data before fetch, and a global
// stall that drops once every active requester has its result.
module pipemem_arbiter
    import pipemem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              ireq,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] irdata,
    input  logic              dreq,
    input  logic              dwe,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dwdata,
    output logic [DATA_W-1:0] drdata,
    output logic              mem_stall,
    output logic              mreq,
    output logic              mwe,
    output logic [ADDR_W-1:0] maddr,
    output logic [DATA_W-1:0] mwdata,
    input  logic [DATA_W-1:0] mrdata,
    input  logic              mack,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0] state;
    logic       idone;
    logic       ddone;
    logic       stall_raw;
    logic       busy;
    logic       issue;
    logic       tmr_dec;
    logic       tmr_expire;

    assign stall_raw = (ireq & ~idone) | (dreq & ~ddone);
    // Held low during reset so the pipeline is not frozen by a cleared done flag.
    assign mem_stall = resetn & stall_raw;
    assign busy      = (state != ST_IDLE);
    // In IDLE a stall always means some requester still needs an access.
    assign issue     = (state == ST_IDLE) & stall_raw;
    assign tmr_dec   = busy & ~mack;

    pipemem_timer #(
        .CNT_W    (CNT_W)
    ) u_timer (
        .clock    (clock),
        .resetn   (resetn),
        .load     (issue),
        .load_val (CNT_W'(TIMEOUT)),
        .dec      (tmr_dec),
        .expire   (tmr_expire)
    );

    // Issue/complete FSM, memory port registers, result registers and done flags.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            mreq    <= 1'b0;
            mwe     <= 1'b0;
            maddr   <= '0;
            mwdata  <= '0;
            irdata  <= '0;
            drdata  <= '0;
            bus_err <= 1'b0;
            idone   <= 1'b0;
            ddone   <= 1'b0;
        end else begin
            // Advance edge: the pipeline moves on, results are consumed.
            if (!stall_raw) begin
                idone <= 1'b0;
                ddone <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (dreq && !ddone) begin
                        // The MEM-stage instruction is older, so it goes first.
                        state  <= ST_DBUSY;
                        mreq   <= 1'b1;
                        mwe    <= dwe;
                        maddr  <= daddr;
                        mwdata <= dwdata;
                    end else if (ireq && !idone) begin
                        state <= ST_IBUSY;
                        mreq  <= 1'b1;
                        mwe   <= 1'b0;
                        maddr <= iaddr;
                    end
                end
                ST_IBUSY: begin
                    if (mack) begin
                        state  <= ST_IDLE;
                        mreq   <= 1'b0;
                        irdata <= mrdata;
                        // A fetch abandoned mid-flight still latches but is not marked done.
                        idone  <= ireq;
                    end else if (tmr_expire) begin
                        state   <= ST_IDLE;
                        mreq    <= 1'b0;
                        irdata  <= DATA_W'(TIMEOUT_FILL);
                        idone   <= 1'b1;
                        bus_err <= 1'b1;
                    end
                end
                ST_DBUSY: begin
                    if (mack) begin
                        state <= ST_IDLE;
                        mreq  <= 1'b0;
                        ddone <= dreq;
                        if (!mwe) begin
                            drdata <= mrdata;
                        end
                    end else if (tmr_expire) begin
                        state   <= ST_IDLE;
                        mreq    <= 1'b0;
                        ddone   <= 1'b1;
                        bus_err <= 1'b1;
                        if (!mwe) begin
                            drdata <= DATA_W'(TIMEOUT_FILL);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    mreq  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipemem_arbiter.sv
// Directed bench for pipemem_arbiter: vector table of single pipeline cycles
// plus hand-written back-to-back, timeout and mid-transaction reset sequences.
module tb_pipemem_arbiter;

    logic        clock;
    logic        resetn;
    logic        ireq;
    logic [31:0] iaddr;
    logic [31:0] irdata;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] drdata;
    logic        mem_stall;
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] mrdata;
    logic        mack;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    pipemem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .ireq      (ireq),
        .iaddr     (iaddr),
        .irdata    (irdata),
        .dreq      (dreq),
        .dwe       (dwe),
        .daddr     (daddr),
        .dwdata    (dwdata),
        .drdata    (drdata),
        .mem_stall (mem_stall),
        .mreq      (mreq),
        .mwe       (mwe),
        .maddr     (maddr),
        .mwdata    (mwdata),
        .mrdata    (mrdata),
        .mack      (mack),
        .bus_err   (bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model contents.
    function automatic logic [31:0] data_of(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h8C22_0004;
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory responder: acks after wait_n busy cycles; wait_n < 0 never acks.
    int wait_n = 0;
    int mcnt   = 0;
    assign mack   = mreq && (wait_n >= 0) && (mcnt == wait_n);
    assign mrdata = data_of(maddr);

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } tx_t;

    tx_t         txlog[$];
    int          mreq_cyc = 0;
    int          hold_err = 0;
    logic        in_tx    = 1'b0;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    logic        h_we;

    // Transaction log, mreq cycle count and port-stability monitor.
    always @(posedge clock) begin
        if (mreq) begin
            mreq_cyc <= mreq_cyc + 1;
            if (in_tx && ((maddr !== h_addr) || (mwdata !== h_wdata) || (mwe !== h_we)))
                hold_err <= hold_err + 1;
            h_addr  <= maddr;
            h_wdata <= mwdata;
            h_we    <= mwe;
        end
        in_tx <= mreq && !mack && resetn;
        if (mreq && mack) txlog.push_back('{maddr, mwe, mwdata});
        if (!resetn || !mreq || mack) mcnt <= 0;
        else mcnt <= mcnt + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One pipeline cycle: apply requests after the previous advance edge,
    // count stall cycles until mem_stall falls (bounded).
    task automatic pipe_cycle(input logic i_r, input logic [31:0] i_a,
                              input logic d_r, input logic d_w,
                              input logic [31:0] d_a, input logic [31:0] d_wd,
                              input int w, output int stalls);
        @(negedge clock);
        ireq = i_r; iaddr = i_a; dreq = d_r; dwe = d_w; daddr = d_a; dwdata = d_wd;
        wait_n = w;
        txlog.delete();
        mreq_cyc = 0;
        #1;
        stalls = 0;
        while (mem_stall && stalls < 60) begin
            stalls++;
            @(negedge clock);
        end
        if (mem_stall) check("stall_bound", 32'd1, 32'd0);
    endtask

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        int          wait_n;
        int          exp_stalls;
        logic [31:0] exp_irdata;
        logic [31:0] exp_drdata;
        int          exp_ntx;
        logic [31:0] exp_a0;
        logic        exp_we0;
        logic [31:0] exp_wd0;
        logic [31:0] exp_a1;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int st;
        vecs[0] = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,        0, 2, 32'h8C220004, 32'h0,        1, 32'h40,  1'b0, 32'h0,        32'h0};
        vecs[1] = '{1'b1, 32'h44,  1'b1, 1'b0, 32'h100, 32'h0,        0, 4, 32'h5A5A0044, 32'h5A5A0100, 2, 32'h100, 1'b0, 32'h0,        32'h44};
        vecs[2] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 3, 5, 32'h5A5A0044, 32'h5A5A0100, 1, 32'h200, 1'b1, 32'hCAFEF00D, 32'h0};
        vecs[3] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h300, 32'h0,        1, 3, 32'h5A5A0044, 32'h5A5A0300, 1, 32'h300, 1'b0, 32'h0,        32'h0};
        vecs[4] = '{1'b1, 32'h48,  1'b1, 1'b0, 32'h104, 32'h0,        2, 8, 32'h5A5A0048, 32'h5A5A0104, 2, 32'h104, 1'b0, 32'h0,        32'h48};
        vecs[5] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        0, 0, 32'h5A5A0048, 32'h5A5A0104, 0, 32'h0,   1'b0, 32'h0,        32'h0};

        resetn = 1'b0; ireq = 1'b0; iaddr = '0; dreq = 1'b0; dwe = 1'b0; daddr = '0; dwdata = '0;
        repeat (2) @(negedge clock);
        check("rst_mreq",      {31'b0, mreq},      32'd0);
        check("rst_mem_stall", {31'b0, mem_stall}, 32'd0);
        check("rst_bus_err",   {31'b0, bus_err},   32'd0);
        check("rst_irdata",    irdata,             32'd0);
        check("rst_drdata",    drdata,             32'd0);
        check("rst_maddr",     maddr,              32'd0);
        resetn = 1'b1;

        // Vector table: one pipeline cycle per entry.
        foreach (vecs[k]) begin
            pipe_cycle(vecs[k].ireq, vecs[k].iaddr, vecs[k].dreq, vecs[k].dwe,
                       vecs[k].daddr, vecs[k].dwdata, vecs[k].wait_n, st);
            check($sformatf("v%0d_stalls", k), st, vecs[k].exp_stalls);
            check($sformatf("v%0d_irdata", k), irdata, vecs[k].exp_irdata);
            check($sformatf("v%0d_drdata", k), drdata, vecs[k].exp_drdata);
            check($sformatf("v%0d_ntx", k), txlog.size(), vecs[k].exp_ntx);
            if (txlog.size() >= 1 && vecs[k].exp_ntx >= 1) begin
                check($sformatf("v%0d_addr0", k), txlog[0].addr, vecs[k].exp_a0);
                check($sformatf("v%0d_we0", k), {31'b0, txlog[0].we}, {31'b0, vecs[k].exp_we0});
                if (vecs[k].exp_we0) check($sformatf("v%0d_wdata0", k), txlog[0].wdata, vecs[k].exp_wd0);
            end
            if (txlog.size() >= 2 && vecs[k].exp_ntx >= 2)
                check($sformatf("v%0d_addr1", k), txlog[1].addr, vecs[k].exp_a1);
        end
        check("port_stable", hold_err, 32'd0);

        // Back-to-back fetches: one transaction per pipeline cycle, in order.
        for (int k = 0; k < 10; k++) begin
            logic [31:0] a;
            a = 32'h1000 + 32'(4 * k);
            pipe_cycle(1'b1, a, 1'b0, 1'b0, 32'h0, 32'h0, 0, st);
            check($sformatf("b2b%0d_stalls", k), st, 32'd2);
            check($sformatf("b2b%0d_ntx", k), txlog.size(), 32'd1);
            check($sformatf("b2b%0d_mreq_cyc", k), mreq_cyc, 32'd1);
            if (txlog.size() >= 1) check($sformatf("b2b%0d_addr", k), txlog[0].addr, a);
            check($sformatf("b2b%0d_irdata", k), irdata, a ^ 32'h5A5A_0000);
        end

        // Timeout: no acknowledge ever, TIMEOUT=4.
        pipe_cycle(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, -1, st);
        check("to_stalls",   st,                 32'd5);
        check("to_mreq_cyc", mreq_cyc,           32'd4);
        check("to_mreq",     {31'b0, mreq},      32'd0);
        check("to_bus_err",  {31'b0, bus_err},   32'd1);
        check("to_irdata",   irdata,             32'd0);
        pipe_cycle(1'b1, 32'h84, 1'b0, 1'b0, 32'h0, 32'h0, 0, st);
        check("to_next_stalls",  st,               32'd2);
        check("to_next_irdata",  irdata,           32'h5A5A0084);
        check("to_bus_err_held", {31'b0, bus_err}, 32'd1);

        // Reset asserted while a load is stuck in DBUSY.
        @(negedge clock);
        ireq = 1'b0; dreq = 1'b1; dwe = 1'b0; daddr = 32'h400; wait_n = -1;
        @(negedge clock);
        @(negedge clock);
        check("mid_mreq_before", {31'b0, mreq}, 32'd1);
        check("mid_maddr",       maddr,         32'h400);
        resetn = 1'b0;
        #1;
        check("mid_rst_mreq",      {31'b0, mreq},      32'd0);
        check("mid_rst_mem_stall", {31'b0, mem_stall}, 32'd0);
        check("mid_rst_bus_err",   {31'b0, bus_err},   32'd0);
        @(negedge clock);
        dreq = 1'b0;
        resetn = 1'b1;
        pipe_cycle(1'b1, 32'h88, 1'b0, 1'b0, 32'h0, 32'h0, 0, st);
        check("post_rst_stalls", st,     32'd2);
        check("post_rst_irdata", irdata, 32'h5A5A0088);
        check("post_rst_ntx",    txlog.size(), 32'd1);
        if (txlog.size() >= 1) check("post_rst_addr", txlog[0].addr, 32'h88);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipemem_arbiter.md
Name: pipemem_arbiter

Overview:
- Shares one single-port unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (lw/sw).
- Sequences at most one memory transaction at a time using a req/ack handshake.
- Holds a single global stall output low only when every active requester has its result for the current pipeline cycle.
- Sits between the pipeline stage registers and the memory model/controller; its stall output feeds the pipeline stall network alongside the ID-stage load-use stall.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- TIMEOUT, 255, maximum cycles mreq may stay high without mack before the access is aborted; must be >= 1.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ireq  in  1  IF wants an instruction word this pipeline cycle.
- iaddr  in  ADDR_W  fetch address (pc).
- irdata  out  DATA_W  fetched instruction, valid when mem_stall=0.
- dreq  in  1  MEM stage access this pipeline cycle.
- dwe  in  1  1=store, 0=load.
- daddr  in  ADDR_W  data address (malu).
- dwdata  in  DATA_W  store data.
- drdata  out  DATA_W  load data, valid when mem_stall=0 and dwe=0.
- mem_stall  out  1  freeze all pipeline registers and pc.
- mreq  out  1  memory request, registered.
- mwe  out  1  memory write enable, registered.
- maddr  out  ADDR_W  memory address, registered.
- mwdata  out  DATA_W  memory write data, registered.
- mrdata  in  DATA_W  memory read data, sampled on mack.
- mack  in  1  one-cycle completion, legal in any cycle mreq=1, including the first.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, any time, including mid-transaction): state IDLE; mreq, mwe, maddr, mwdata, irdata, drdata, bus_err, idone, ddone, timeout counter all 0. An abandoned memory transaction is discarded by the memory side.
- mem_stall is combinational: (ireq & ~idone) | (dreq & ~ddone).
- Advance cycle = cycle with mem_stall=0. At its rising edge, clear idone and ddone; no issue occurs in that cycle.
- FSM states:
  - IDLE: if dreq & ~ddone, go to DBUSY and register dwe/daddr/dwdata onto the memory port with mreq=1. Else if ireq & ~idone, go to IBUSY with mwe=0 and maddr=iaddr. Else stay.
  - Data has fixed priority over fetch: the older instruction goes first.
  - IBUSY/DBUSY: hold mreq, mwe, maddr, mwdata stable. On mack: mreq←0, return to IDLE.
    - IBUSY: irdata←mrdata, idone←1.
    - DBUSY: set ddone←1. If load, drdata←mrdata; store leaves drdata unchanged.
- No preemption: a granted transaction runs to mack or timeout.
- Latency: one access with mack in the first mreq cycle gives 2 stall cycles (issue, busy); mem_stall falls in the 3rd cycle. Both requesters present gives 4 stall cycles, data first.
- irdata/drdata hold their value until overwritten by a later completion.
- Requester deasserting ireq/dreq while its transaction is in flight: the transaction completes, but the done flag is not set and data is still latched.
- Timeout: counter resets on entering BUSY and increments each BUSY cycle without mack. On reaching TIMEOUT: mreq←0, bus_err←1 (sticky until reset), done flag set, read data register←0, go to IDLE.
- mack while state is IDLE: ignored.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, IBUSY=2'd1, DBUSY=2'd2) and a constant for the timeout fill value 32'h0.
- One natural sub-module: pipemem_timer, a loadable down-counter with an expire flag used for the timeout. All else stays in the top level.

Test Plan:
- Fetch only: ireq=1, iaddr=0x00000040, memory acks in the first mreq cycle with 0x8C220004 -> mem_stall high for 2 cycles, mreq high exactly 1 cycle at maddr 0x40, irdata=0x8C220004 when mem_stall falls.
- Simultaneous: ireq=1 (iaddr 0x44), dreq=1 load (daddr 0x100) -> memory sees 0x100 then 0x44, 4 stall cycles, drdata and irdata correct in the advance cycle.
- Store with 3 wait states: dreq=1, dwe=1, daddr=0x200, dwdata=0xCAFEF00D, mack on the 4th mreq cycle -> mwe=1, maddr/mwdata stable throughout, drdata unchanged, mem_stall low in the following cycle.
- Timeout with TIMEOUT=4, mack never asserted -> mreq drops after 4 busy cycles, bus_err=1 and stays 1, irdata=0, pipeline advances.
- Reset mid-DBUSY: resetn low while mreq=1 -> mreq, mem_stall, bus_err go 0 immediately without a clock edge; after release a fresh ireq issues normally.
- Back-to-back pipeline: 10 consecutive fetches with single-cycle mack -> exactly one memory transaction per pipeline cycle, no duplicated or skipped addresses.
